// File: rtl/icmp_pkg.sv
// Shared ICMP constants, receive-parser state encoding and the checksum fold helper.
package icmp_pkg;

    localparam logic [7:0] ICMP_TYPE_ECHO_REQ   = 8'd8;
    localparam logic [7:0] ICMP_TYPE_ECHO_REPLY = 8'd0;
    localparam int         ICMP_HDR_LEN         = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_HOLD    = 3'd4,
        ST_SKIP    = 3'd5
    } icmp_state_e;

    // Two passes suffice: the first leaves at most 0x1FFFE, the second at most 0xFFFF.
    function automatic logic [15:0] csum_fold(input logic [31:0] acc);
        logic [31:0] s;
        s = {16'h0000, acc[31:16]} + {16'h0000, acc[15:0]};
        s = {16'h0000, s[31:16]} + {16'h0000, s[15:0]};
        return s[15:0];
    endfunction

endpackage

// File: rtl/icmp_pl_ram.sv
// Echo payload buffer: simple dual-port RAM, one write port and one registered read port.
module icmp_pl_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/icmp_echo_rx.sv
// ICMP receive parser: filters echo requests, buffers the payload and raises a valid/ready reply request.
// Define ICMP_CSUM_CHECK_EN to also drop echo requests whose ones-complement checksum does not verify.
module icmp_echo_rx #(
    parameter int MAX_PAYLOAD = 1024,
    parameter int AW          = $clog2(MAX_PAYLOAD),
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_icmp_data,
    input  logic [15:0]      i_icmp_len,
    input  logic             i_icmp_last,
    input  logic             i_icmp_valid,
    output logic             o_req_valid,
    input  logic             i_req_ready,
    output logic [15:0]      o_req_id,
    output logic [15:0]      o_req_seq,
    output logic [15:0]      o_req_len,
    input  logic [AW-1:0]    i_pl_rd_addr,
    output logic [7:0]       o_pl_rd_data,
    output logic [CNT_W-1:0] o_drop_cnt,
    output logic [CNT_W-1:0] o_runt_cnt
);

    import icmp_pkg::*;

    localparam logic [15:0] HDR_LEN_W = 16'(ICMP_HDR_LEN);
    localparam logic [15:0] PL_LIMIT  = 16'(ICMP_HDR_LEN + MAX_PAYLOAD);

    logic        in_vld_q;
    logic        in_last_q;
    logic [7:0]  in_data_q;
    logic [15:0] in_len_q;

    icmp_state_e      state_q;
    logic [15:0]      cnt_q;
    logic [15:0]      pkt_len_q;
    logic [15:0]      hdr_id_q;
    logic [15:0]      hdr_seq_q;
    logic             oversize_q;
    logic             req_valid_q;
    logic [15:0]      req_id_q;
    logic [15:0]      req_seq_q;
    logic [15:0]      req_len_q;
    logic [CNT_W-1:0] drop_q;
    logic [CNT_W-1:0] runt_q;
    logic             sh_act_q;
    logic             sh_echo_q;
    logic [15:0]      sh_cnt_q;

    logic          sh_claim;
    logic          main_byte;
    logic          in_hdr;
    logic          hdr_bad;
    logic          main_runt;
    logic          csum_bad;
    logic          chk_err;
    logic          chk_drop;
    logic [15:0]   sh_total;
    logic          sh_end;
    logic          sh_echo_now;
    logic          sh_drop;
    logic          sh_runt;
    logic          pl_we;
    logic [AW-1:0] pl_waddr;

    // Input register stage: all parsing below works on this copy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            in_vld_q <= 1'b0;
        end else begin
            in_vld_q <= i_icmp_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        in_data_q <= i_icmp_data;
        in_last_q <= i_icmp_last;
        in_len_q  <= i_icmp_len;
    end

    // A packet that starts while a request is checked or pending belongs to the shadow tracker
    // until its last byte, even if the request is accepted in the meantime.
    always_comb begin
        sh_claim    = in_vld_q && (sh_act_q || state_q == ST_CHECK || state_q == ST_HOLD);
        main_byte   = in_vld_q && !sh_claim;
        in_hdr      = (state_q == ST_IDLE) || (state_q == ST_HDR);
        hdr_bad     = ((cnt_q == 16'd0) && (in_data_q != ICMP_TYPE_ECHO_REQ))
                   || ((cnt_q == 16'd1) && (in_data_q != 8'h00));
        main_runt   = main_byte && in_hdr && in_last_q && (cnt_q < 16'd7);
        chk_err     = oversize_q || (cnt_q != pkt_len_q) || csum_bad;
        chk_drop    = (state_q == ST_CHECK) && chk_err;
        sh_total    = sh_cnt_q + 16'd1;
        sh_end      = sh_claim && in_last_q;
        sh_echo_now = (sh_cnt_q == 16'd0) ? (in_data_q == ICMP_TYPE_ECHO_REQ) : sh_echo_q;
        sh_drop     = sh_end && (sh_total >= HDR_LEN_W) && sh_echo_now;
        sh_runt     = sh_end && (sh_total < HDR_LEN_W);
        pl_we       = main_byte && (state_q == ST_PAYLOAD) && (cnt_q < PL_LIMIT);
        pl_waddr    = AW'(cnt_q - HDR_LEN_W);
    end

    always_ff @(posedge i_clk) begin
        if (main_byte && in_hdr) begin
            case (cnt_q)
                16'd0:   pkt_len_q       <= in_len_q;
                16'd4:   hdr_id_q[15:8]  <= in_data_q;
                16'd5:   hdr_id_q[7:0]   <= in_data_q;
                16'd6:   hdr_seq_q[15:8] <= in_data_q;
                16'd7:   hdr_seq_q[7:0]  <= in_data_q;
                default: ;
            endcase
        end
    end

`ifdef ICMP_CSUM_CHECK_EN
    logic [31:0] csum_acc_q;
    logic [15:0] csum_word;

    // Even offsets are the high byte of a big-endian word; an odd trailing byte is zero-padded low.
    assign csum_word = cnt_q[0] ? {8'h00, in_data_q} : {in_data_q, 8'h00};

    always_ff @(posedge i_clk) begin
        if (main_byte && (in_hdr || state_q == ST_PAYLOAD)) begin
            csum_acc_q <= ((cnt_q == 16'd0) ? 32'd0 : csum_acc_q) + {16'h0000, csum_word};
        end
    end

    assign csum_bad = (csum_fold(csum_acc_q) != 16'hFFFF);
`else
    assign csum_bad = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            oversize_q  <= 1'b0;
            req_valid_q <= 1'b0;
            req_id_q    <= 16'd0;
            req_seq_q   <= 16'd0;
            req_len_q   <= 16'd0;
            drop_q      <= '0;
            runt_q      <= '0;
            sh_act_q    <= 1'b0;
            sh_echo_q   <= 1'b0;
            sh_cnt_q    <= 16'd0;
        end else begin
            drop_q <= drop_q + CNT_W'(chk_drop) + CNT_W'(sh_drop);
            runt_q <= runt_q + CNT_W'(main_runt) + CNT_W'(sh_runt);

            if (sh_claim) begin
                if (in_last_q) begin
                    sh_act_q <= 1'b0;
                    sh_cnt_q <= 16'd0;
                end else begin
                    sh_act_q  <= 1'b1;
                    sh_cnt_q  <= sh_total;
                    sh_echo_q <= sh_echo_now;
                end
            end

            case (state_q)
                ST_IDLE, ST_HDR: begin
                    if (main_byte) begin
                        if (in_last_q && cnt_q < 16'd7) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= 16'd0;
                        end else if (hdr_bad) begin
                            state_q <= ST_SKIP;
                            cnt_q   <= cnt_q + 16'd1;
                        end else if (cnt_q == 16'd7) begin
                            state_q <= in_last_q ? ST_CHECK : ST_PAYLOAD;
                            cnt_q   <= cnt_q + 16'd1;
                        end else begin
                            state_q <= ST_HDR;
                            cnt_q   <= cnt_q + 16'd1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (main_byte) begin
                        cnt_q <= cnt_q + 16'd1;
                        if (cnt_q >= PL_LIMIT) begin
                            oversize_q <= 1'b1;
                        end
                        if (in_last_q) begin
                            state_q <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    cnt_q      <= 16'd0;
                    oversize_q <= 1'b0;
                    if (chk_err) begin
                        state_q <= ST_IDLE;
                    end else begin
                        req_valid_q <= 1'b1;
                        req_id_q    <= hdr_id_q;
                        req_seq_q   <= hdr_seq_q;
                        req_len_q   <= pkt_len_q - HDR_LEN_W;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (req_valid_q && i_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_SKIP: begin
                    if (main_byte) begin
                        if (in_last_q) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= 16'd0;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    icmp_pl_ram #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW)
    ) u_pl_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .we_i    (pl_we),
        .waddr_i (pl_waddr),
        .wdata_i (in_data_q),
        .raddr_i (i_pl_rd_addr),
        .rdata_o (o_pl_rd_data)
    );

    assign o_req_valid = req_valid_q;
    assign o_req_id    = req_id_q;
    assign o_req_seq   = req_seq_q;
    assign o_req_len   = req_len_q;
    assign o_drop_cnt  = drop_q;
    assign o_runt_cnt  = runt_q;

endmodule

// File: doc/icmp_echo_rx.md
Name: icmp_echo_rx

Overview:
- Parametrised ICMP receive parser; sits between the IP RX demux and the ICMP TX builder.
- Parses the header of an ICMP byte stream.
- Filters for echo requests and optionally verifies the checksum.
- Buffers the echo payload so the TX side can replay it.
- Presents identifier, sequence and payload length to TX through a valid/ready request handshake, instead of a one-cycle trigger.

Parameters:
- MAX_PAYLOAD, 1024: payload buffer depth in bytes. Must be a power of two.
- AW, $clog2(MAX_PAYLOAD): payload buffer address width. Derived; do not override.
- CNT_W, 16: width of the statistics counters.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_icmp_data  in  8  ICMP byte stream, first byte = type.
- i_icmp_len  in  16  total ICMP length in bytes (header + payload). Stable while i_icmp_valid is high.
- i_icmp_last  in  1  marks the final byte.
- i_icmp_valid  in  1  byte qualifier. Contiguous per packet; no backpressure.
- o_req_valid  out  1  echo reply request pending.
- i_req_ready  in  1  TX accepts the request.
- o_req_id  out  16  echo identifier, big-endian from bytes 4-5.
- o_req_seq  out  16  echo sequence, big-endian from bytes 6-7.
- o_req_len  out  16  payload length = i_icmp_len - 8.
- i_pl_rd_addr  in  AW  payload buffer read address.
- o_pl_rd_data  out  8  payload byte; registered, 1-cycle read latency.
- o_drop_cnt  out  CNT_W  echo requests dropped (busy/oversize/length error/checksum).
- o_runt_cnt  out  CNT_W  packets ending before byte 8.

Behaviour:
- Input registered once; all parsing works on the registered copy.
- Byte counter: zero in idle, increments per valid byte.
- FSM states:
  - IDLE: first valid byte → HDR.
  - HDR: capture bytes 0..7 (type, code, checksum, id, seq).
    - Byte 0 != 8 or code != 0 → SKIP.
    - Last before byte 7 → count runt, → IDLE.
    - Byte 7 with last → CHECK (zero payload).
    - Byte 7 otherwise → PAYLOAD.
  - PAYLOAD: write byte at address (count-8).
    - Address ≥ MAX_PAYLOAD → set oversize flag; stop writing.
    - On last → CHECK.
  - CHECK (1 cycle):
    - Error if oversize, or byte count != i_icmp_len, or checksum bad (when enabled). Error → drop_cnt+1, → IDLE.
    - Otherwise o_req_valid←1, → HOLD.
  - HOLD: o_req_* and buffer frozen until o_req_valid & i_req_ready; then o_req_valid←0, → IDLE (same edge).
  - SKIP: wait for last → IDLE. No counter change.
- Packet arriving while in HOLD:
  - Tracked by a shadow byte counter only; buffer not written.
  - If it is an echo request (byte 0 == 8) and ≥8 bytes: drop_cnt+1.
  - If <8 bytes: runt_cnt+1.
  - Shadow tracking runs in parallel with HOLD.
  - If handshake and shadow-packet end coincide, the shadow packet is still dropped.
- Latency: last byte sampled at edge N → o_req_valid high after edge N+2.
- Counters wrap at 2^CNT_W.
- Reset values: o_req_valid 0, o_req_id/seq/len 0, o_pl_rd_data 0, counters 0, FSM IDLE. Reset mid-packet: remaining bytes of that packet are seen as a new packet starting mid-stream.
  - Remaining tail has ≥8 bytes: parsed as a new packet and almost always filtered or dropped by the type/length checks.
  - Remaining tail has <8 bytes: runt.
- i_req_ready while o_req_valid low: ignored.

Optional Feature:
- Macro: ICMP_CSUM_CHECK_EN.
- Defined:
  - 32-bit accumulator sums big-endian 16-bit words over all bytes, including the checksum field.
  - Odd trailing byte padded with 0x00 low.
  - Carries folded twice.
  - Packet valid only if folded result == 16'hFFFF; otherwise dropped in CHECK.
- Undefined: no accumulator; checksum field captured but ignored.

Decomposition:
- Shared package icmp_pkg:
  - ICMP_TYPE_ECHO_REQ=8, ICMP_TYPE_ECHO_REPLY=0, ICMP_HDR_LEN=8.
  - FSM state encoding.
  - Checksum fold function.
- One sub-module: icmp_pl_ram, a simple dual-port RAM (1 write, 1 registered read), depth MAX_PAYLOAD.

Test Plan:
- Echo req, id 0x1234, seq 0x0007, 32-byte payload 0x00..0x1F, good checksum → o_req_valid at N+2; id=0x1234, seq=0x0007, len=32; read addr 5 → 0x05 next cycle.
- Type 0 (reply) packet, 40 bytes → no o_req_valid; drop_cnt and runt_cnt stay 0.
- 6-byte packet (last at byte 5) → runt_cnt=1, no request.
- Second echo req arriving while i_req_ready held low → drop_cnt=1; first request fields/payload unchanged; ready pulse → valid drops next edge.
- Echo req with checksum corrupted (0xFFFF xor 1): macro defined → drop_cnt=1; macro undefined → request issued.
- Echo req of 8+MAX_PAYLOAD+1 bytes → drop_cnt=1. Also i_icmp_len=48 with 40 bytes delivered → drop_cnt+1.
